// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game-state core.
// Covers the direction encoding, FSM states, grid defaults and the reset layout helper.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   localparam int GRID_W_DEF = 32;
   localparam int GRID_H_DEF = 24;

   function automatic dir_t opposite(input dir_t d);
      case (d)
         DIR_UP:   return DIR_DOWN;
         DIR_DOWN: return DIR_UP;
         DIR_LEFT: return DIR_RIGHT;
         default:  return DIR_LEFT;
      endcase
   endfunction

   // Reset layout: a horizontal run leftwards from the grid centre; segments
   // beyond the initial length pile up on the initial tail cell.
   function automatic int init_seg_x(input int grid_w, input int init_len, input int i);
      return grid_w / 2 - ((i < init_len - 1) ? i : init_len - 1);
   endfunction

endpackage

// File: rtl/snake_dir_ctrl.sv
// Direction request logic: button priority, reversal filter, and the pend/dir registers.
// dir only changes on a committed move, so reversal is judged against the real heading.
module snake_dir_ctrl
   import snake_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_en,
   input  logic       update_en,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic [1:0] pend,
   output logic [1:0] dir,
   output logic       accept
);

   dir_t req;
   logic any_btn;

   always_comb begin
      req     = DIR_RIGHT;
      any_btn = btn_up | btn_down | btn_left | btn_right;
      if (btn_up)
         req = DIR_UP;
      else if (btn_down)
         req = DIR_DOWN;
      else if (btn_left)
         req = DIR_LEFT;
      accept = sample_en && any_btn && (req != opposite(dir_t'(dir)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= DIR_RIGHT;
         dir  <= DIR_RIGHT;
      end else begin
         if (update_en)
            dir <= pend;
         if (accept)
            pend <= req;
      end
   end

endmodule

// File: rtl/snake_engine.sv
// Snake game-state core: body shift register, move/collision logic and game FSM.
// Occupancy queries are combinational so the renderer and food generator see the live body.
//
//   state   | meaning
//   --------+----------------------------------------------------
//   ST_IDLE | reset layout shown, waiting for a non-reversing press
//   ST_RUN  | snake advances one cell per update tick
//   ST_DEAD | wall or self collision seen; frozen until rst
module snake_engine
   import snake_pkg::*;
#(
   parameter int GRID_W   = GRID_W_DEF,
   parameter int GRID_H   = GRID_H_DEF,
   parameter int X_W      = 5,
   parameter int Y_W      = 5,
   parameter int MAX_LEN  = 16,
   parameter int INIT_LEN = 3,
   parameter int L_W      = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           update,
   input  logic           btn_up,
   input  logic           btn_down,
   input  logic           btn_left,
   input  logic           btn_right,
   input  logic [X_W-1:0] food_x,
   input  logic [Y_W-1:0] food_y,
   input  logic           food_valid,
   input  logic [X_W-1:0] query_x,
   input  logic [Y_W-1:0] query_y,
   output logic           query_body,
   output logic           query_head,
   output logic [X_W-1:0] head_x,
   output logic [Y_W-1:0] head_y,
   output logic [L_W-1:0] length,
   output logic           ate,
   output logic           running,
   output logic           game_over
);

   state_t         state;
   logic [X_W-1:0] seg_x [MAX_LEN];
   logic [Y_W-1:0] seg_y [MAX_LEN];
   logic [1:0]     pend;
   logic [1:0]     dir;
   logic           accept;
   logic [X_W-1:0] nh_x;
   logic [Y_W-1:0] nh_y;
   logic           wall_hit;
   logic           grow;
   logic           self_hit;
   logic           collide;

   snake_dir_ctrl u_dir_ctrl (
      .clk       (clk),
      .rst       (rst),
      .sample_en (state != ST_DEAD),
      .update_en (update && (state == ST_RUN) && !collide),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .pend      (pend),
      .dir       (dir),
      .accept    (accept)
   );

   // nh wraps on a wall hit, but wall_hit forces a collision so it is never stored.
   always_comb begin
      nh_x     = seg_x[0];
      nh_y     = seg_y[0];
      wall_hit = 1'b0;
      case (pend)
         DIR_UP: begin
            wall_hit = (seg_y[0] == '0);
            nh_y     = seg_y[0] - Y_W'(1);
         end
         DIR_DOWN: begin
            wall_hit = (seg_y[0] == Y_W'(GRID_H - 1));
            nh_y     = seg_y[0] + Y_W'(1);
         end
         DIR_LEFT: begin
            wall_hit = (seg_x[0] == '0);
            nh_x     = seg_x[0] - X_W'(1);
         end
         default: begin
            wall_hit = (seg_x[0] == X_W'(GRID_W - 1));
            nh_x     = seg_x[0] + X_W'(1);
         end
      endcase
   end

   assign grow = food_valid && (nh_x == food_x) && (nh_y == food_y);

   // The tail cell only counts as occupied when growing, since otherwise it vacates this tick.
   always_comb begin
      self_hit = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         if (((i + 1) < int'(length)) || (grow && ((i + 1) == int'(length)))) begin
            if ((seg_x[i] == nh_x) && (seg_y[i] == nh_y))
               self_hit = 1'b1;
         end
      end
   end

   assign collide = wall_hit | self_hit;

   always_comb begin
      query_body = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if ((i < int'(length)) && (seg_x[i] == query_x) && (seg_y[i] == query_y))
            query_body = 1'b1;
      end
   end

   assign query_head = (seg_x[0] == query_x) && (seg_y[0] == query_y);
   assign head_x     = seg_x[0];
   assign head_y     = seg_y[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         length    <= L_W'(INIT_LEN);
         ate       <= 1'b0;
         running   <= 1'b0;
         game_over <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= X_W'(init_seg_x(GRID_W, INIT_LEN, i));
            seg_y[i] <= Y_W'(GRID_H / 2);
         end
      end else begin
         ate <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
            end
            ST_RUN: begin
               if (update) begin
                  if (collide) begin
                     state     <= ST_DEAD;
                     running   <= 1'b0;
                     game_over <= 1'b1;
                  end else begin
                     for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                     end
                     seg_x[0] <= nh_x;
                     seg_y[0] <= nh_y;
                     if (grow) begin
                        ate <= 1'b1;
                        if (length != L_W'(MAX_LEN))
                           length <= length + L_W'(1);
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: directed scenarios plus a randomized run
// against a queue-based model of the snake (head at the front, tail at the back).
module tb_snake_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       update = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic [4:0] food_x = '0;
   logic [4:0] food_y = '0;
   logic       food_valid = 1'b0;
   logic [4:0] query_x = '0;
   logic [4:0] query_y = '0;
   logic       query_body, query_head;
   logic [4:0] head_x, head_y, length;
   logic       ate, running, game_over;

   int n_cmp = 0;
   int n_err = 0;

   // model: 0 idle, 1 run, 2 dead; directions 0 up, 1 down, 2 left, 3 right
   int m_st, m_dir, m_pend;
   int mx[$];
   int my[$];
   bit m_ate;

   snake_engine dut (
      .clk(clk), .rst(rst), .update(update),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
      .query_x(query_x), .query_y(query_y),
      .query_body(query_body), .query_head(query_head),
      .head_x(head_x), .head_y(head_y), .length(length),
      .ate(ate), .running(running), .game_over(game_over)
   );

   always #5 clk = ~clk;

   function automatic int opp(input int d);
      return (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 3 : 2;
   endfunction

   function automatic bit m_body(input int x, input int y);
      foreach (mx[i]) if (mx[i] == x && my[i] == y) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step();
      int req, nx, ny, lim;
      bit any, acc, wall, grow, hit;
      if (rst) begin
         m_st = 0; m_dir = 3; m_pend = 3; m_ate = 0;
         mx = {}; my = {};
         for (int i = 0; i < 3; i++) begin mx.push_back(16 - i); my.push_back(12); end
         return;
      end
      m_ate = 0;
      if (m_st == 2) return;
      any = btn_up | btn_down | btn_left | btn_right;
      req = btn_up ? 0 : btn_down ? 1 : btn_left ? 2 : 3;
      acc = any && (req != opp(m_dir));
      if (m_st == 0) begin
         if (acc) m_st = 1;
      end else if (update) begin
         nx = mx[0]; ny = my[0];
         case (m_pend)
            0: ny = ny - 1;
            1: ny = ny + 1;
            2: nx = nx - 1;
            default: nx = nx + 1;
         endcase
         wall = (nx < 0) || (nx > 31) || (ny < 0) || (ny > 23);
         grow = food_valid && (nx == int'(food_x)) && (ny == int'(food_y));
         lim  = grow ? mx.size() : mx.size() - 1;
         hit  = 0;
         for (int i = 1; i < lim; i++) if (mx[i] == nx && my[i] == ny) hit = 1;
         if (wall || hit) m_st = 2;
         else begin
            mx.push_front(nx); my.push_front(ny);
            if (!grow || mx.size() > 16) begin void'(mx.pop_back()); void'(my.pop_back()); end
            m_ate = grow;
            m_dir = m_pend;
         end
      end
      if (acc) m_pend = req;
   endtask

   task automatic cycle(input logic u, input logic d, input logic l, input logic r, input logic upd);
      btn_up = u; btn_down = d; btn_left = l; btn_right = r; update = upd;
      model_step();
      @(posedge clk); #1;
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; update = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (head_x !== 5'd16 || head_y !== 5'd12) begin n_err++; $display("FAIL reset_head got (%0d,%0d) want (16,12)", head_x, head_y); end
      n_cmp++; if (length !== 5'd3) begin n_err++; $display("FAIL reset_length got %0d want 3", length); end
      n_cmp++; if (game_over !== 1'b0 || running !== 1'b0 || ate !== 1'b0) begin n_err++; $display("FAIL reset_flags got go=%b run=%b ate=%b want 0 0 0", game_over, running, ate); end
      query_x = 14; query_y = 12; #1;
      n_cmp++; if (query_body !== 1'b1 || query_head !== 1'b0) begin n_err++; $display("FAIL reset_query_14_12 got body=%b head=%b want 1 0", query_body, query_head); end
      query_x = 13; #1;
      n_cmp++; if (query_body !== 1'b0) begin n_err++; $display("FAIL reset_query_13_12 got body=%b want 0", query_body); end
      query_x = 16; #1;
      n_cmp++; if (query_body !== 1'b1 || query_head !== 1'b1) begin n_err++; $display("FAIL reset_query_head got body=%b head=%b want 1 1", query_body, query_head); end
   endtask

   task automatic test_idle();
      repeat (3) begin cycle(0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 0); end
      n_cmp++; if (head_x !== 5'd16 || head_y !== 5'd12) begin n_err++; $display("FAIL idle_static got (%0d,%0d) want (16,12)", head_x, head_y); end
      cycle(0, 0, 1, 0, 0);
      n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL idle_left_ignored got running=%b want 0", running); end
      cycle(1, 0, 0, 0, 0);
      n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL idle_up_starts got running=%b want 1", running); end
      cycle(0, 0, 0, 0, 1);
      n_cmp++; if (head_x !== 5'd16 || head_y !== 5'd11) begin n_err++; $display("FAIL idle_first_move got (%0d,%0d) want (16,11)", head_x, head_y); end
   endtask

   task automatic test_reversal();
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 1);
      n_cmp++; if (head_x !== 5'd17 || head_y !== 5'd11) begin n_err++; $display("FAIL rev_turn_right got (%0d,%0d) want (17,11)", head_x, head_y); end
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 1);
      n_cmp++; if (head_x !== 5'd17 || head_y !== 5'd10) begin n_err++; $display("FAIL rev_left_filtered got (%0d,%0d) want (17,10)", head_x, head_y); end
   endtask

   task automatic test_growth();
      do_reset();
      cycle(0, 0, 0, 1, 0);
      food_x = 17; food_y = 12; food_valid = 1;
      cycle(0, 0, 0, 0, 1);
      food_valid = 0;
      query_x = 14; query_y = 12; #1;
      n_cmp++; if (ate !== 1'b1 || length !== 5'd4) begin n_err++; $display("FAIL grow_first got ate=%b len=%0d want 1 4", ate, length); end
      n_cmp++; if (query_body !== 1'b1 || head_x !== 5'd17) begin n_err++; $display("FAIL grow_tail_kept got body=%b hx=%0d want 1 17", query_body, head_x); end
      cycle(0, 0, 0, 0, 0);
      n_cmp++; if (ate !== 1'b0) begin n_err++; $display("FAIL grow_ate_pulse got ate=%b want 0", ate); end
      for (int k = 0; k < 12; k++) begin
         food_x = head_x + 5'd1; food_valid = 1;
         cycle(0, 0, 0, 0, 1);
      end
      n_cmp++; if (length !== 5'd16 || head_x !== 5'd29) begin n_err++; $display("FAIL grow_to_max got len=%0d hx=%0d want 16 29", length, head_x); end
      food_x = 30; food_valid = 1;
      cycle(0, 0, 0, 0, 1);
      food_valid = 0;
      n_cmp++; if (ate !== 1'b1 || length !== 5'd16) begin n_err++; $display("FAIL grow_saturate got ate=%b len=%0d want 1 16", ate, length); end
   endtask

   task automatic test_wall();
      cycle(0, 0, 0, 0, 1);
      n_cmp++; if (head_x !== 5'd31 || game_over !== 1'b0) begin n_err++; $display("FAIL wall_edge got hx=%0d go=%b want 31 0", head_x, game_over); end
      cycle(0, 0, 0, 0, 1);
      n_cmp++; if (game_over !== 1'b1 || running !== 1'b0 || head_x !== 5'd31 || head_y !== 5'd12) begin n_err++; $display("FAIL wall_hit got go=%b run=%b head=(%0d,%0d) want 1 0 (31,12)", game_over, running, head_x, head_y); end
      cycle(1, 0, 0, 0, 0); cycle(0, 0, 0, 0, 1); cycle(0, 1, 0, 0, 1);
      n_cmp++; if (game_over !== 1'b1 || head_x !== 5'd31 || head_y !== 5'd12 || length !== 5'd16) begin n_err++; $display("FAIL dead_frozen got go=%b head=(%0d,%0d) len=%0d want 1 (31,12) 16", game_over, head_x, head_y, length); end
   endtask

   task automatic test_self_collision();
      do_reset();
      cycle(0, 0, 0, 1, 0);
      food_x = 17; food_y = 12; food_valid = 1; cycle(0, 0, 0, 0, 1);
      food_x = 18; cycle(0, 0, 0, 0, 1);
      food_valid = 0;
      n_cmp++; if (length !== 5'd5) begin n_err++; $display("FAIL self_len got %0d want 5", length); end
      cycle(0, 0, 0, 0, 1);
      cycle(0, 1, 0, 0, 0); cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 1, 0, 0); cycle(0, 0, 0, 0, 1);
      n_cmp++; if (head_x !== 5'd18 || head_y !== 5'd13 || game_over !== 1'b0) begin n_err++; $display("FAIL self_pre got (%0d,%0d) go=%b want (18,13) 0", head_x, head_y, game_over); end
      cycle(1, 0, 0, 0, 0); cycle(0, 0, 0, 0, 1);
      n_cmp++; if (game_over !== 1'b1 || head_x !== 5'd18 || head_y !== 5'd13) begin n_err++; $display("FAIL self_hit got go=%b head=(%0d,%0d) want 1 (18,13)", game_over, head_x, head_y); end
   endtask

   task automatic test_reset_dead();
      do_reset();
      n_cmp++; if (game_over !== 1'b0 || head_x !== 5'd16 || head_y !== 5'd12 || length !== 5'd3) begin n_err++; $display("FAIL dead_reset got go=%b head=(%0d,%0d) len=%0d want 0 (16,12) 3", game_over, head_x, head_y, length); end
   endtask

   task automatic test_tail_chase();
      int ex[4] = '{17, 16, 16, 17};
      int ey[4] = '{13, 13, 12, 12};
      do_reset();
      cycle(0, 0, 0, 1, 0);
      food_x = 17; food_y = 12; food_valid = 1; cycle(0, 0, 0, 0, 1);
      food_valid = 0;
      for (int r = 0; r < 3; r++) begin
         for (int s = 0; s < 4; s++) begin
            cycle(s == 2, s == 0, s == 1, s == 3, 0);
            cycle(0, 0, 0, 0, 1);
            n_cmp++; if (running !== 1'b1 || head_x !== ex[s][4:0] || head_y !== ey[s][4:0]) begin n_err++; $display("FAIL tail_chase r%0d s%0d got run=%b head=(%0d,%0d) want 1 (%0d,%0d)", r, s, running, head_x, head_y, ex[s], ey[s]); end
         end
      end
   endtask

   task automatic test_random();
      int fx, fy, qi, bad;
      bad = 0;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] b;
         b = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         fx = mx[0] + $urandom_range(0, 2) - 1;
         fy = my[0] + $urandom_range(0, 2) - 1;
         food_x = fx[4:0]; food_y = fy[4:0];
         food_valid = ($urandom_range(0, 2) != 0);
         rst = (m_st == 2 && $urandom_range(0, 7) == 0);
         cycle(b[0], b[1], b[2], b[3], $urandom_range(0, 2) == 0);
         rst = 0;
         if ($urandom_range(0, 1) == 0 && mx.size() > 0) begin
            qi = $urandom_range(0, mx.size() - 1);
            query_x = mx[qi][4:0]; query_y = my[qi][4:0];
         end else begin
            query_x = 5'($urandom_range(0, 31)); query_y = 5'($urandom_range(0, 23));
         end
         #1;
         n_cmp++;
         if (head_x !== mx[0][4:0] || head_y !== my[0][4:0] || length !== 5'(mx.size()) || ate !== m_ate
             || running !== (m_st == 1) || game_over !== (m_st == 2)
             || query_body !== m_body(int'(query_x), int'(query_y))
             || query_head !== (int'(query_x) == mx[0] && int'(query_y) == my[0])) begin
            n_err++;
            if (bad < 10) $display("FAIL random n%0d got head=(%0d,%0d) len=%0d ate=%b run=%b go=%b qb=%b qh=%b want head=(%0d,%0d) len=%0d ate=%b st=%0d qb=%b",
               n, head_x, head_y, length, ate, running, game_over, query_body, query_head, mx[0], my[0], mx.size(), m_ate, m_st, m_body(int'(query_x), int'(query_y)));
            bad++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_reversal();
      test_growth();
      test_wall();
      test_reset_dead();
      test_self_collision();
      test_reset_dead();
      test_tail_chase();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
